// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage defaults and the fetch FSM state type
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with flush > stall-hold > load > consume priority
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc    <= 32'h0000_0000;
      pc4   <= 32'h0000_0004;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!(stall && valid)) begin
      if (load) begin
        instr <= load_instr;
        pc    <= load_pc;
        pc4   <= load_pc + 32'd4;
        valid <= 1'b1;
      end else if (!stall) begin
        // downstream took the word and nothing new arrived: present a bubble
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, single-outstanding imem handshake, skid buffer, IF/ID
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRvalid,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr,
  output logic [31:0] PC_ID,
  output logic [31:0] PC4_ID,
  output logic        InstrValid
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4, redirect_target;
  logic [31:0]  skid_instr, skid_pc;
  logic         slot_free, load_mem, load_skid, skid_capture;
  logic         id_load;
  logic [31:0]  id_load_instr, id_load_pc;

  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = RedirectPC & 32'hFFFF_FFFC;
  assign slot_free       = ~InstrValid | ~Stall;

  assign IMemReq  = (state == FETCH) & ~Redirect & ~Reset;
  assign IMemAddr = pc;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    load_mem     = 1'b0;
    load_skid    = 1'b0;
    skid_capture = 1'b0;
    case (state)
      FETCH: begin
        if (Redirect) pc_next = redirect_target;
        else          state_next = WAIT;
      end
      WAIT: begin
        if (IMemRvalid) begin
          state_next = FETCH;
          if (Redirect) begin
            pc_next = redirect_target;
          end else begin
            pc_next = pc_plus4;
            if (slot_free) begin
              load_mem = 1'b1;
            end else begin
              skid_capture = 1'b1;
              state_next   = HOLD;
            end
          end
        end else if (Redirect) begin
          // the in-flight response still has to be swallowed before refetching
          pc_next    = redirect_target;
          state_next = DROP;
        end
      end
      DROP: begin
        if (Redirect)   pc_next = redirect_target;
        if (IMemRvalid) state_next = FETCH;
      end
      HOLD: begin
        if (Redirect) begin
          pc_next    = redirect_target;
          state_next = FETCH;
        end else if (!Stall) begin
          load_skid  = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // buffer contents are only meaningful while in HOLD
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid_instr <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (skid_capture) begin
        skid_instr <= IMemRdata;
        skid_pc    <= pc;
      end
    end
  end

  assign id_load       = load_mem | load_skid;
  assign id_load_instr = load_skid ? skid_instr : IMemRdata;
  assign id_load_pc    = load_skid ? skid_pc : pc;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (Clk),
    .reset     (Reset),
    .flush     (Redirect),
    .stall     (Stall),
    .load      (id_load),
    .load_instr(id_load_instr),
    .load_pc   (id_load_pc),
    .instr     (Instr),
    .pc        (PC_ID),
    .pc4       (PC4_ID),
    .valid     (InstrValid)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a transaction-level fetch model
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_id, pc4_id;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Stall     (stall),
    .Redirect  (redirect),
    .RedirectPC(redirect_pc),
    .IMemReq   (imem_req),
    .IMemAddr  (imem_addr),
    .IMemRvalid(rvalid),
    .IMemRdata (rdata),
    .Instr     (instr),
    .PC_ID     (pc_id),
    .PC4_ID    (pc4_id),
    .InstrValid(instr_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: word_at = 32'h0050_0093;
      32'h0000_0004: word_at = 32'h00A0_0113;
      default:       word_at = 32'hC000_0000 ^ a;
    endcase
  endfunction

  // memory responder
  int          lat = 1;
  int          cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  logic        last_req;
  logic [31:0] req_log[$];

  // model: one request in flight (busy), its response to be dropped (stale),
  // a parked word (buf), and the word currently offered to decode (slot)
  bit          model_ok = 1'b0;
  bit          m_busy, m_stale, m_buf_v, m_v;
  logic [31:0] m_pc, m_buf_w, m_buf_pc, m_instr, m_pcid;

  task automatic cyc();
    bit          req_e, got, free;
    bit          n_busy, n_stale, n_buf_v, n_v;
    logic [31:0] n_pc, n_buf_w, n_buf_pc, n_instr, n_pcid;
    bit          req_seen;
    logic [31:0] req_addr_seen;

    @(negedge clk);
    req_e = !m_busy && !m_buf_v && !redirect && !reset;
    if (model_ok) begin
      check1("req", imem_req, req_e);
      if (req_e) check32("addr", imem_addr, m_pc);
      check32("instr", instr, m_instr);
      check32("pc_id", pc_id, m_pcid);
      check32("pc4_id", pc4_id, m_pcid + 32'd4);
      check1("valid", instr_valid, m_v);
    end
    last_req      = imem_req;
    req_seen      = imem_req;
    req_addr_seen = imem_addr;
    if (imem_req) req_log.push_back(imem_addr);

    n_busy = m_busy; n_stale = m_stale; n_buf_v = m_buf_v; n_v = m_v;
    n_pc = m_pc; n_buf_w = m_buf_w; n_buf_pc = m_buf_pc; n_instr = m_instr; n_pcid = m_pcid;
    if (reset) begin
      n_pc = 32'h0; n_busy = 0; n_stale = 0; n_buf_v = 0;
      n_v = 0; n_instr = NOP; n_pcid = 32'h0;
    end else begin
      got  = m_busy && rvalid && !m_stale && !redirect;
      free = !m_v || !stall;
      if (redirect) begin
        n_v = 0; n_instr = NOP;
      end else if (m_v && stall) begin
        n_v = m_v;
      end else if (got && free) begin
        n_v = 1; n_instr = rdata; n_pcid = m_pc;
      end else if (m_buf_v && !stall) begin
        n_v = 1; n_instr = m_buf_w; n_pcid = m_buf_pc;
      end else if (!stall) begin
        n_v = 0; n_instr = NOP;
      end
      if (m_busy && rvalid) begin
        n_busy = 0; n_stale = 0;
        if (got) begin
          n_pc = m_pc + 32'd4;
          if (!free) begin
            n_buf_v = 1; n_buf_w = rdata; n_buf_pc = m_pc;
          end
        end
      end
      if (m_buf_v && !stall) n_buf_v = 0;
      if (req_e) begin
        n_busy = 1; n_stale = 0;
      end
      if (redirect) begin
        n_pc = redirect_pc & 32'hFFFF_FFFC;
        n_buf_v = 0;
        if (m_busy && !rvalid) n_stale = 1;
      end
    end

    @(posedge clk);
    #1;
    m_busy = n_busy; m_stale = n_stale; m_buf_v = n_buf_v; m_v = n_v;
    m_pc = n_pc; m_buf_w = n_buf_w; m_buf_pc = n_buf_pc; m_instr = n_instr; m_pcid = n_pcid;
    if (reset) model_ok = 1'b1;

    if (reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (rvalid) pend = 1'b0;
      else        cnt--;
    end
    if (req_seen) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = req_addr_seen;
    end
    rvalid = pend && (cnt == 1);
    rdata  = rvalid ? word_at(paddr) : 32'hDEAD_BEEF;
  endtask

  task automatic check_if(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc, input logic e_valid);
    check32({tag, "_instr"}, instr, e_instr);
    check32({tag, "_pc_id"}, pc_id, e_pc);
    check32({tag, "_pc4_id"}, pc4_id, e_pc + 32'd4);
    check1({tag, "_valid"}, instr_valid, e_valid);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rvalid = 1'b0; rdata = '0;

    // reset values
    cyc(); cyc();
    check1("rst_req", last_req, 1'b0);
    check_if("rst", NOP, 32'h0, 1'b0);

    // two sequential fetches at latency 1
    reset = 1'b0;
    req_log.delete();
    cyc();
    cyc();
    check_if("seq0", 32'h0050_0093, 32'h0, 1'b1);
    cyc();
    check_if("seq_gap", NOP, 32'h0, 1'b0);
    cyc();
    check_if("seq1", 32'h00A0_0113, 32'h4, 1'b1);
    check32("seq_addr0", req_log[0], 32'h0);
    check32("seq_addr1", req_log[1], 32'h4);

    // stall for 5 cycles; the fetch of 0x8 returns mid-stall and parks
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check32("stall_instr", instr, 32'h00A0_0113);
      check32("stall_pc_id", pc_id, 32'h4);
    end
    check32("stall_nreq", req_log.size(), 32'd3);
    check32("stall_addr", req_log[2], 32'h8);
    stall = 1'b0;
    cyc();
    check_if("unstall", 32'hC000_0008, 32'h8, 1'b1);
    check32("unstall_nreq", req_log.size(), 32'd3);
    lat = 4;
    cyc();
    check32("next_addr", req_log[3], 32'hC);

    // redirect while waiting; the stale response arrives 3 cycles later
    redirect = 1'b1; redirect_pc = 32'h0000_0100; lat = 1;
    cyc();
    check_if("redir", NOP, 32'h8, 1'b0);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check32("drop_instr", instr, NOP);
    end
    check32("drop_nreq", req_log.size(), 32'd4);
    cyc();
    check32("redir_addr", req_log[4], 32'h100);
    cyc();
    check_if("redir_word", 32'hC000_0100, 32'h100, 1'b1);

    // flush beats stall; target low bits are ignored
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
    cyc();
    check1("flush_req", last_req, 1'b0);
    check32("flush_instr", instr, NOP);
    check1("flush_valid", instr_valid, 1'b0);
    stall = 1'b0; redirect = 1'b0;
    cyc();
    check32("align_addr", req_log[$], 32'h200);
    cyc();
    check_if("align_word", 32'hC000_0200, 32'h200, 1'b1);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect = 1'b0;
    cyc();
    check32("top_addr", req_log[$], 32'hFFFF_FFFC);
    cyc();
    check32("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    check32("wrap_pc4_id", pc4_id, 32'h0);
    check32("wrap_instr", instr, 32'h3FFF_FFFC);
    cyc();
    check32("wrap_addr", req_log[$], 32'h0);
    cyc();
    check_if("wrap_word", 32'h0050_0093, 32'h0, 1'b1);

    // reset while waiting, with the response in the same cycle
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    cyc();
    redirect = 1'b0;
    cyc();
    cyc();
    check_if("pre_rst", 32'hC000_0040, 32'h40, 1'b1);
    stall = 1'b1;
    cyc();
    check32("pre_rst_addr", req_log[$], 32'h44);
    reset = 1'b1;
    cyc();
    check1("mid_rst_req", last_req, 1'b0);
    check_if("mid_rst", NOP, 32'h0, 1'b0);
    reset = 1'b0; stall = 1'b0;
    cyc();
    check32("restart_addr", req_log[$], 32'h0);
    cyc();
    check_if("restart_word", 32'h0050_0093, 32'h0, 1'b1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
